// File: rtl/param_reg_file_pkg.sv
// Shared defaults and byte-lane helpers for the parameterised register file.
package param_reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/param_reg_file_scoreboard.sv
// Pending-load scoreboard: one busy flag per register, set by reserve, cleared by write.
module reg_scoreboard
  import param_reg_file_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [(2**ADDR_W)-1:0] busy_nxt
);

  logic [(2**ADDR_W)-1:0] busy_q;
  logic [(2**ADDR_W)-1:0] busy_d;

  // Clear is applied before set so a same-cycle reserve of the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)  busy_d[wr_addr]  = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy     = busy_q;
  assign busy_nxt = busy_d;

endmodule

// File: rtl/param_reg_file.sv
// Two-read/one-write register file with byte enables, write-first bypass and a load scoreboard.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W/8-1:0]    wr_be,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic [ADDR_W-1:0]      rd_addr2,
  output logic [DATA_W-1:0]      rd_data1,
  output logic [DATA_W-1:0]      rd_data2,
  output logic                   rd_valid,
  output logic                   rd_busy1,
  output logic                   rd_busy2,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_busy1_q, rd_busy1_d;
  logic              rd_busy2_q, rd_busy2_d;
  logic [DEPTH-1:0]  busy_nxt;

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_nxt (busy_nxt)
  );

  always_comb begin
    for (int r = 0; r < DEPTH; r++) mem_d[r] = mem_q[r];
    if (wr_en && !(ZERO_R0 && wr_addr == '0)) begin
      for (int b = 0; b < NB; b++) begin
        mem_d[wr_addr][8*b +: 8] = merge_byte(mem_q[wr_addr][8*b +: 8],
                                              wr_data[8*b +: 8], wr_be[b]);
      end
    end
    if (ZERO_R0) mem_d[0] = '0;
  end

  // Reads sample the post-write array and next-state busy, giving write-first behaviour.
  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    rd_busy1_d = rd_busy1_q;
    rd_busy2_d = rd_busy2_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      rd_data1_d = mem_d[rd_addr1];
      rd_data2_d = mem_d[rd_addr2];
      rd_busy1_d = busy_nxt[rd_addr1];
      rd_busy2_d = busy_nxt[rd_addr2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
      rd_busy1_q <= 1'b0;
      rd_busy2_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= mem_d[r];
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_valid_q <= rd_valid_d;
      rd_busy1_q <= rd_busy1_d;
      rd_busy2_q <= rd_busy2_d;
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign rd_valid = rd_valid_q;
  assign rd_busy1 = rd_busy1_q;
  assign rd_busy2 = rd_busy2_q;

endmodule
